// File: rtl/seq_mult_param.sv
// Digit-serial WIDTHxWIDTH multiplier/MAC: one DIGITxDIGIT partial product per cycle, optional signed mode.
// Result and one-cycle done pulse (N*N)+1 edges after start; start is ignored while busy, never queued.
module seq_mult_param #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic                 acc_en,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   d_out,
  output logic                 busy,
  output logic                 done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int NN = N * N;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    mag_a, mag_b;
  logic [2*WIDTH-1:0]  mag;
  logic [CW-1:0]       cnt;
  logic                neg, acc_q;

  logic [DIGIT-1:0]    dig_a, dig_b;
  logic [2*DIGIT-1:0]  pp;
  logic [2*WIDTH-1:0]  pp_sh;
  logic [2*WIDTH-1:0]  res;
  int                  i_idx, j_idx;

  // |x| of the most negative value still fits the unsigned W-bit register.
  logic [WIDTH-1:0]    abs_a, abs_b;
  assign abs_a = (signed_mode && a[WIDTH-1]) ? -a : a;
  assign abs_b = (signed_mode && b[WIDTH-1]) ? -b : b;

  assign busy = (state != IDLE);

  always_comb begin
    i_idx = int'(cnt) / N;
    j_idx = int'(cnt) % N;
    dig_a = DIGIT'(mag_a >> (DIGIT * i_idx));
    dig_b = DIGIT'(mag_b >> (DIGIT * j_idx));
    pp    = (2*DIGIT)'(dig_a) * (2*DIGIT)'(dig_b);
    pp_sh = (2*WIDTH)'(pp) << (DIGIT * (i_idx + j_idx));
    res   = neg ? -mag : mag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(NN - 1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_a <= '0;
      mag_b <= '0;
      mag   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      acc_q <= 1'b0;
      d_out <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag_a <= abs_a;
            mag_b <= abs_b;
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q <= acc_en;
            mag   <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          mag <= mag + pp_sh;
          cnt <= cnt + CW'(1);
        end
        FIN: begin
          d_out <= (acc_q ? d_out : '0) + res;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: three instances (8/4, 16/4, 8/8) checked every cycle against an arithmetic model,
// plus directed operations with literal expected results and latencies.
module tb_seq_mult_param;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        st = '0, sm = '0, ac = '0;
  logic [2:0][15:0]  ia = '0, ib = '0;
  logic [15:0]       d0, d2;
  logic [31:0]       d1;
  logic [2:0]        bz, dn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_mult_param #(.WIDTH(8), .DIGIT(4)) dut0 (
    .clk(clk), .rst(rst_n), .start(st[0]), .signed_mode(sm[0]), .acc_en(ac[0]),
    .a(ia[0][7:0]), .b(ib[0][7:0]), .d_out(d0), .busy(bz[0]), .done(dn[0]));
  seq_mult_param #(.WIDTH(16), .DIGIT(4)) dut1 (
    .clk(clk), .rst(rst_n), .start(st[1]), .signed_mode(sm[1]), .acc_en(ac[1]),
    .a(ia[1]), .b(ib[1]), .d_out(d1), .busy(bz[1]), .done(dn[1]));
  seq_mult_param #(.WIDTH(8), .DIGIT(8)) dut2 (
    .clk(clk), .rst(rst_n), .start(st[2]), .signed_mode(sm[2]), .acc_en(ac[2]),
    .a(ia[2][7:0]), .b(ib[2][7:0]), .d_out(d2), .busy(bz[2]), .done(dn[2]));

  function automatic int nn(int k);
    return (k == 1) ? 16 : (k == 2) ? 1 : 4;
  endfunction

  function automatic int wd(int k);
    return (k == 1) ? 16 : 8;
  endfunction

  function automatic logic [31:0] msk(longint v, int w);
    longint m;
    m = (longint'(1) << (2 * w)) - 1;
    return 32'(v & m);
  endfunction

  // Product modulo 2^(2w), operands read as w-bit unsigned or two's complement.
  function automatic logic [31:0] prodf(logic [15:0] x, logic [15:0] y, bit s, int w);
    longint sx, sy, m;
    m  = (longint'(1) << w) - 1;
    sx = longint'(x) & m;
    sy = longint'(y) & m;
    if (s) begin
      if (sx >= (longint'(1) << (w - 1))) sx = sx - (longint'(1) << w);
      if (sy >= (longint'(1) << (w - 1))) sy = sy - (longint'(1) << w);
    end
    return msk(sx * sy, w);
  endfunction

  function automatic logic [31:0] gd(int k);
    return (k == 0) ? {16'h0, d0} : (k == 1) ? d1 : {16'h0, d2};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: operation accepted when idle, result lands nn+1 edges later.
  int           rem   [3];
  logic [31:0]  prd   [3];
  bit           accq  [3];
  logic [31:0]  exp_d [3];
  bit           exp_dn[3];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        rem[k] <= 0; prd[k] <= '0; accq[k] <= 1'b0; exp_d[k] <= '0; exp_dn[k] <= 1'b0;
      end else if (rem[k] == 0) begin
        exp_dn[k] <= 1'b0;
        if (st[k]) begin
          rem[k]  <= nn(k) + 1;
          prd[k]  <= prodf(ia[k], ib[k], sm[k], wd(k));
          accq[k] <= ac[k];
        end
      end else begin
        rem[k] <= rem[k] - 1;
        exp_dn[k] <= (rem[k] == 1);
        if (rem[k] == 1)
          exp_d[k] <= accq[k] ? msk(longint'(exp_d[k]) + longint'(prd[k]), wd(k)) : prd[k];
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("busy%0d", k), 32'(bz[k]), 32'(rem[k] != 0));
      chk($sformatf("done%0d", k), 32'(dn[k]), 32'(exp_dn[k]));
      chk($sformatf("dout%0d", k), gd(k), exp_d[k]);
      chk($sformatf("busy_done_excl%0d", k), 32'(dn[k] & bz[k]), 32'h0);
    end
  end

  logic [31:0] lastv [3];

  // Starts at the current time (caller is just after an edge with the instance idle).
  task automatic run_op(int k, logic [15:0] x, logic [15:0] y, bit s, bit acc,
                        logic [31:0] expv, bit inject, string name);
    int n;
    bit got;
    st[k] = 1'b1; ia[k] = x; ib[k] = y; sm[k] = s; ac[k] = acc;
    @(posedge clk); #1;
    st[k] = 1'b0; ia[k] = 16'($urandom); ib[k] = 16'($urandom); sm[k] = ~s; ac[k] = ~acc;
    n = 0; got = 1'b0;
    while (!got && n < 300) begin
      st[k] = (inject && n == 1);
      @(posedge clk); #1;
      n++;
      if (dn[k]) got = 1'b1;
    end
    st[k] = 1'b0;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no done after %0d edges", name, n);
    end else begin
      chk({name, "_lat"}, 32'(n), 32'(nn(k) + 1));
      chk({name, "_val"}, gd(k), expv);
    end
    lastv[k] = expv;
  endtask

  initial begin
    logic [15:0] x, y;
    bit s, acc;
    logic [31:0] p, e;
    for (int k = 0; k < 3; k++) lastv[k] = '0;

    #3;
    chk("rst_d0", {16'h0, d0}, 32'h0);
    chk("rst_d1", d1, 32'h0);
    chk("rst_d2", {16'h0, d2}, 32'h0);
    chk("rst_busy", 32'(bz), 32'h0);
    chk("rst_done", 32'(dn), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 16'hFF, 16'hFF, 0, 0, 32'hFE01, 0, "u_ff_ff");
    run_op(0, 16'h80, 16'h80, 1, 0, 32'h4000, 0, "s_80_80");
    run_op(0, 16'h80, 16'h7F, 1, 0, 32'hC080, 0, "s_80_7f");
    run_op(0, 16'hFF, 16'h01, 1, 0, 32'hFFFF, 0, "s_ff_01");
    run_op(0, 16'hFF, 16'hFF, 0, 0, 32'hFE01, 0, "acc_base");
    run_op(0, 16'h02, 16'h03, 0, 1, 32'hFE07, 0, "acc_add");
    run_op(0, 16'hFF, 16'hFF, 0, 1, 32'hFC08, 0, "acc_wrap");
    run_op(0, 16'h02, 16'h03, 1, 0, 32'h0006, 0, "sacc_base");
    run_op(0, 16'hFF, 16'h03, 1, 1, 32'h0003, 0, "sacc_neg");
    run_op(0, 16'h12, 16'h34, 0, 0, 32'h03A8, 1, "start_in_calc");
    run_op(0, 16'h05, 16'h07, 0, 0, 32'h0023, 0, "back_to_back");

    // Abort mid-operation with an asynchronous reset.
    st[0] = 1'b1; ia[0] = 16'h55; ib[0] = 16'h66; sm[0] = 0; ac[0] = 0;
    @(posedge clk); #1;
    st[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_d0", {16'h0, d0}, 32'h0);
    chk("midrst_busy", 32'(bz[0]), 32'h0);
    chk("midrst_done", 32'(dn[0]), 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) lastv[k] = '0;
    run_op(0, 16'h0C, 16'h0D, 0, 0, 32'h009C, 0, "after_rst");

    run_op(1, 16'hFFFF, 16'hFFFF, 0, 0, 32'hFFFE0001, 0, "w16_u");
    run_op(1, 16'h8000, 16'h8000, 1, 0, 32'h40000000, 0, "w16_s");
    run_op(2, 16'h0F, 16'h0F, 0, 0, 32'h00E1, 0, "d8_u");
    run_op(2, 16'h80, 16'hFF, 1, 0, 32'h0080, 0, "d8_s");
    run_op(2, 16'h10, 16'h10, 0, 1, 32'h0180, 0, "d8_acc");

    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 10; r++) begin
        x = 16'($urandom); y = 16'($urandom);
        s = 1'($urandom); acc = 1'($urandom);
        p = prodf(x, y, s, wd(k));
        e = acc ? msk(longint'(lastv[k]) + longint'(p), wd(k)) : p;
        run_op(k, x, y, s, acc, e, 0, $sformatf("rand%0d", k));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
